lcd_bus_rx: RTL and testbench

//  Receive side of the 8080-style parallel LCD bus driven by the screen display block
//   (lcd_db/lcd_wr/lcd_d_c/lcd_rd/lcd_reset).

---
 rtl/lcd_bus_rx_pkg.sv | 24 ++
 rtl/lcd_bus_rx_sync.sv | 58 +++++
 rtl/lcd_bus_rx.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_lcd_bus_rx.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_bus_rx_pkg.sv
// Package asteroids: shared definitions for the LCD bus receiver.
//   LCD_CMD_CASET / LCD_CMD_PASET / LCD_CMD_RAMWR : decoded command codes
//   lcd_rx_state_t                                : decoder FSM states
//   rgb565_to_444()                               : keeps the 4 MSBs of each RGB565 channel
package asteroids;

  localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
  localparam logic [7:0] LCD_CMD_PASET = 8'h2B;
  localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    PASET,
    RAM_HI,
    RAM_LO
  } lcd_rx_state_t;

  // RGB565 is sent as hi = RRRRRGGG, lo = GGGBBBBB.
  function automatic logic [11:0] rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

endpackage

// File: rtl/lcd_bus_rx_sync.sv
// lcd_bus_sync: brings the asynchronous LCD bus pins into the clk domain.
//   clk, resetN         : sample clock, async active-low reset
//   lcd_db/wr/d_c/rd    : raw bus pins
//   lcd_reset           : raw panel reset pin (active-low)
//   byte_evt            : one-cycle pulse on a synced wr rising edge while rd is high
//   byte_dc, byte_data  : d/c flag and data byte aligned with byte_evt
//   soft_rst            : synced, active-high version of lcd_reset
module lcd_bus_sync (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] lcd_db,
  input  logic       lcd_wr,
  input  logic       lcd_d_c,
  input  logic       lcd_rd,
  input  logic       lcd_reset,
  output logic       byte_evt,
  output logic       byte_dc,
  output logic [7:0] byte_data,
  output logic       soft_rst
);

  logic [1:0] wr_sync;
  logic [1:0] dc_sync;
  logic [1:0] rd_sync;
  logic [1:0] rst_sync;
  logic [7:0] db_s1;
  logic [7:0] db_s2;
  logic       wr_prev;

  // Strobes reset to their idle-high level so that a bus idling with wr=1
  // does not look like a rising edge when resetN releases.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_sync  <= 2'b11;
      wr_prev  <= 1'b1;
      dc_sync  <= 2'b00;
      rd_sync  <= 2'b11;
      rst_sync <= 2'b11;
      db_s1    <= 8'h00;
      db_s2    <= 8'h00;
    end else begin
      wr_sync  <= {wr_sync[0], lcd_wr};
      wr_prev  <= wr_sync[1];
      dc_sync  <= {dc_sync[0], lcd_d_c};
      rd_sync  <= {rd_sync[0], lcd_rd};
      rst_sync <= {rst_sync[0], lcd_reset};
      db_s1    <= lcd_db;
      db_s2    <= db_s1;
    end
  end

  // Data and d/c share the strobe's two-flop depth, so they line up with the edge.
  assign byte_evt  = wr_sync[1] & ~wr_prev & rd_sync[1];
  assign byte_dc   = dc_sync[1];
  assign byte_data = db_s2;
  assign soft_rst  = ~rst_sync[1];

endmodule

// File: rtl/lcd_bus_rx.sv
// lcd_bus_rx: loopback monitor for the 8080-style LCD bus.
// Decodes CASET / PASET / RAMWR and re-emits RAMWR pixels as (x, y, rgb444).
// Optional build macro: LCD_RX_STATS_EN adds frame_cnt, px_cnt and err_cnt outputs.
// Ports:
//   clk, resetN                      : sample clock, async active-low reset
//   lcd_db, lcd_wr, lcd_d_c, lcd_rd  : bus pins (data latched on wr rising edge)
//   lcd_reset                        : panel reset, soft reset of the decoder
//   pxl_valid, pxl_x, pxl_y, pxl_rgb : pixel write strobe and payload
//   frame_start                      : first pixel of a frame at (SC,SP)
//   cmd_valid, cmd_code              : command byte pulse and last command held
module lcd_bus_rx
  import asteroids::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [7:0]                lcd_db,
  input  logic                      lcd_wr,
  input  logic                      lcd_d_c,
  input  logic                      lcd_rd,
  input  logic                      lcd_reset,
  output logic                      pxl_valid,
  output logic [$clog2(WIDTH)-1:0]  pxl_x,
  output logic [$clog2(HEIGHT)-1:0] pxl_y,
  output logic [11:0]               pxl_rgb,
  output logic                      frame_start,
  output logic                      cmd_valid,
  output logic [7:0]                cmd_code
`ifdef LCD_RX_STATS_EN
  ,
  output logic [15:0]               frame_cnt,
  output logic [19:0]               px_cnt,
  output logic [7:0]                err_cnt
`endif
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

  logic       byte_evt;
  logic       byte_dc;
  logic [7:0] byte_data;
  logic       soft_rst;

  lcd_bus_sync u_sync (
    .clk       (clk),
    .resetN    (resetN),
    .lcd_db    (lcd_db),
    .lcd_wr    (lcd_wr),
    .lcd_d_c   (lcd_d_c),
    .lcd_rd    (lcd_rd),
    .lcd_reset (lcd_reset),
    .byte_evt  (byte_evt),
    .byte_dc   (byte_dc),
    .byte_data (byte_data),
    .soft_rst  (soft_rst)
  );

  function automatic logic [XW-1:0] clamp_x(input logic [15:0] v);
    if (v > 16'(WIDTH - 1)) return X_MAX;
    else return v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [15:0] v);
    if (v > 16'(HEIGHT - 1)) return Y_MAX;
    else return v[YW-1:0];
  endfunction

  lcd_rx_state_t state, state_n;
  logic [1:0]    cnt, cnt_n;
  // par_hi holds the pending high byte of a parameter or of a pixel.
  logic [7:0]    par_hi, par_hi_n;
  logic [15:0]   par_start, par_start_n;
  // win_* is the committed window; act_* is the copy latched at RAMWR.
  logic [XW-1:0] win_sc, win_sc_n, win_ec, win_ec_n;
  logic [YW-1:0] win_sp, win_sp_n, win_ep, win_ep_n;
  logic [XW-1:0] act_sc, act_sc_n, act_ec, act_ec_n;
  logic [YW-1:0] act_sp, act_sp_n, act_ep, act_ep_n;
  logic [XW-1:0] cur_x, cur_x_n;
  logic [YW-1:0] cur_y, cur_y_n;
  logic          first_px, first_px_n;
  logic          pxl_valid_n, frame_start_n, cmd_valid_n;
  logic [XW-1:0] pxl_x_n;
  logic [YW-1:0] pxl_y_n;
  logic [11:0]   pxl_rgb_n;
  logic [7:0]    cmd_code_n;

  // Clamped start/end candidates for the 4th parameter byte; a start beyond
  // the end drags the end up with it.
  logic [XW-1:0] col_s, col_e_raw, col_e;
  logic [YW-1:0] row_s, row_e_raw, row_e;

  assign col_s     = clamp_x(par_start);
  assign col_e_raw = clamp_x({par_hi, byte_data});
  assign col_e     = (col_s > col_e_raw) ? col_s : col_e_raw;
  assign row_s     = clamp_y(par_start);
  assign row_e_raw = clamp_y({par_hi, byte_data});
  assign row_e     = (row_s > row_e_raw) ? row_s : row_e_raw;

  // State register for the decoder and all registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      par_hi      <= 8'h00;
      par_start   <= 16'h0000;
      win_sc      <= '0;
      win_ec      <= X_MAX;
      win_sp      <= '0;
      win_ep      <= Y_MAX;
      act_sc      <= '0;
      act_ec      <= X_MAX;
      act_sp      <= '0;
      act_ep      <= Y_MAX;
      cur_x       <= '0;
      cur_y       <= '0;
      first_px    <= 1'b0;
      pxl_valid   <= 1'b0;
      pxl_x       <= '0;
      pxl_y       <= '0;
      pxl_rgb     <= 12'h000;
      frame_start <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_code    <= 8'h00;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      par_hi      <= par_hi_n;
      par_start   <= par_start_n;
      win_sc      <= win_sc_n;
      win_ec      <= win_ec_n;
      win_sp      <= win_sp_n;
      win_ep      <= win_ep_n;
      act_sc      <= act_sc_n;
      act_ec      <= act_ec_n;
      act_sp      <= act_sp_n;
      act_ep      <= act_ep_n;
      cur_x       <= cur_x_n;
      cur_y       <= cur_y_n;
      first_px    <= first_px_n;
      pxl_valid   <= pxl_valid_n;
      pxl_x       <= pxl_x_n;
      pxl_y       <= pxl_y_n;
      pxl_rgb     <= pxl_rgb_n;
      frame_start <= frame_start_n;
      cmd_valid   <= cmd_valid_n;
      cmd_code    <= cmd_code_n;
    end
  end

  // Next-state decode. Soft reset wins over byte events; a command byte
  // always restarts decoding regardless of the current state.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    par_hi_n      = par_hi;
    par_start_n   = par_start;
    win_sc_n      = win_sc;
    win_ec_n      = win_ec;
    win_sp_n      = win_sp;
    win_ep_n      = win_ep;
    act_sc_n      = act_sc;
    act_ec_n      = act_ec;
    act_sp_n      = act_sp;
    act_ep_n      = act_ep;
    cur_x_n       = cur_x;
    cur_y_n       = cur_y;
    first_px_n    = first_px;
    pxl_valid_n   = 1'b0;
    pxl_x_n       = pxl_x;
    pxl_y_n       = pxl_y;
    pxl_rgb_n     = pxl_rgb;
    frame_start_n = 1'b0;
    cmd_valid_n   = 1'b0;
    cmd_code_n    = cmd_code;

    if (soft_rst) begin
      state_n     = IDLE;
      cnt_n       = 2'd0;
      par_hi_n    = 8'h00;
      par_start_n = 16'h0000;
      win_sc_n    = '0;
      win_ec_n    = X_MAX;
      win_sp_n    = '0;
      win_ep_n    = Y_MAX;
      act_sc_n    = '0;
      act_ec_n    = X_MAX;
      act_sp_n    = '0;
      act_ep_n    = Y_MAX;
      cur_x_n     = '0;
      cur_y_n     = '0;
      first_px_n  = 1'b0;
      pxl_x_n     = '0;
      pxl_y_n     = '0;
      pxl_rgb_n   = 12'h000;
    end else if (byte_evt) begin
      if (!byte_dc) begin
        cmd_valid_n = 1'b1;
        cmd_code_n  = byte_data;
        cnt_n       = 2'd0;
        case (byte_data)
          LCD_CMD_CASET: state_n = CASET;
          LCD_CMD_PASET: state_n = PASET;
          LCD_CMD_RAMWR: begin
            state_n    = RAM_HI;
            act_sc_n   = win_sc;
            act_ec_n   = win_ec;
            act_sp_n   = win_sp;
            act_ep_n   = win_ep;
            cur_x_n    = win_sc;
            cur_y_n    = win_sp;
            first_px_n = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end else begin
        case (state)
          CASET, PASET: begin
            cnt_n = cnt + 2'd1;
            case (cnt)
              2'd0: par_hi_n = byte_data;
              2'd1: par_start_n = {par_hi, byte_data};
              2'd2: par_hi_n = byte_data;
              default: begin
                state_n = IDLE;
                if (state == CASET) begin
                  win_sc_n = col_s;
                  win_ec_n = col_e;
                end else begin
                  win_sp_n = row_s;
                  win_ep_n = row_e;
                end
              end
            endcase
          end
          RAM_HI: begin
            par_hi_n = byte_data;
            state_n  = RAM_LO;
          end
          RAM_LO: begin
            state_n       = RAM_HI;
            pxl_valid_n   = 1'b1;
            pxl_x_n       = cur_x;
            pxl_y_n       = cur_y;
            pxl_rgb_n     = rgb565_to_444(par_hi, byte_data);
            frame_start_n = first_px && (cur_x == act_sc) && (cur_y == act_sp);
            first_px_n    = 1'b0;
            if (cur_x == act_ec) begin
              cur_x_n = act_sc;
              if (cur_y == act_ep) begin
                cur_y_n    = act_sp;
                first_px_n = 1'b1;
              end else begin
                cur_y_n = cur_y + 1'b1;
              end
            end else begin
              cur_x_n = cur_x + 1'b1;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

`ifdef LCD_RX_STATS_EN
  // Protocol errors: stray data in IDLE, or a command cutting short a
  // parameter list or a half-received pixel.
  logic err_evt;
  assign err_evt = byte_evt && !soft_rst &&
                   (byte_dc ? (state == IDLE)
                            : (state == CASET || state == PASET || state == RAM_LO));

  // Counters run off the registered pixel strobes; the frame's own first
  // pixel is counted, so px_cnt restarts at 1 on frame_start.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt <= 16'h0000;
      px_cnt    <= 20'h00000;
      err_cnt   <= 8'h00;
    end else if (soft_rst) begin
      frame_cnt <= 16'h0000;
      px_cnt    <= 20'h00000;
      err_cnt   <= 8'h00;
    end else begin
      if (frame_start) frame_cnt <= frame_cnt + 16'd1;
      if (pxl_valid) px_cnt <= frame_start ? 20'd1 : px_cnt + 20'd1;
      if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_bus_rx.sv
// tb_lcd_bus_rx: directed bench for lcd_bus_rx.
// Drives 8080 bus writes at a safe pace (>= 2 clk per strobe phase), records
// every emitted pixel at the falling clock edge and compares against
// hand-computed expectations per scenario.
module tb_lcd_bus_rx;

  logic       clk;
  logic       resetN;
  logic [7:0] lcd_db;
  logic       lcd_wr;
  logic       lcd_d_c;
  logic       lcd_rd;
  logic       lcd_reset;
  logic       pxl_valid;
  logic [9:0] pxl_x;
  logic [8:0] pxl_y;
  logic [11:0] pxl_rgb;
  logic       frame_start;
  logic       cmd_valid;
  logic [7:0] cmd_code;
`ifdef LCD_RX_STATS_EN
  logic [15:0] frame_cnt;
  logic [19:0] px_cnt;
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad = 0;
  int cmd_seen = 0;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] rgb;
    logic        fs;
  } pix_t;

  pix_t pq[$];

  lcd_bus_rx #(.WIDTH(640), .HEIGHT(480)) dut (
    .clk         (clk),
    .resetN      (resetN),
    .lcd_db      (lcd_db),
    .lcd_wr      (lcd_wr),
    .lcd_d_c     (lcd_d_c),
    .lcd_rd      (lcd_rd),
    .lcd_reset   (lcd_reset),
    .pxl_valid   (pxl_valid),
    .pxl_x       (pxl_x),
    .pxl_y       (pxl_y),
    .pxl_rgb     (pxl_rgb),
    .frame_start (frame_start),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code)
`ifdef LCD_RX_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .px_cnt      (px_cnt),
    .err_cnt     (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel and command recorder, sampled away from the active edge.
  always @(negedge clk) begin
    if (pxl_valid) pq.push_back({pxl_x, pxl_y, pxl_rgb, frame_start});
    if (cmd_valid) cmd_seen++;
  end

  task automatic bus_write(input logic dc, input logic [7:0] d, input logic rd);
    @(posedge clk);
    #1;
    lcd_d_c = dc;
    lcd_db  = d;
    lcd_rd  = rd;
    lcd_wr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lcd_wr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lcd_rd = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    bus_write(1'b0, c, 1'b1);
  endtask

  task automatic send_data(input logic [7:0] d);
    bus_write(1'b1, d, 1'b1);
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
  endtask

  task automatic test_reset();
    resetN    = 1'b0;
    lcd_wr    = 1'b1;
    lcd_rd    = 1'b1;
    lcd_reset = 1'b1;
    lcd_d_c   = 1'b0;
    lcd_db    = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({pxl_valid, frame_start, cmd_valid} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_strobes got=%b want=000", {pxl_valid, frame_start, cmd_valid});
    end
    total++;
    if ({pxl_x, pxl_y, pxl_rgb} !== 31'd0) begin
      bad++;
      $display("[TB] FAIL reset_pixel got=%0h want=0", {pxl_x, pxl_y, pxl_rgb});
    end
    total++;
    if (cmd_code !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_cmd_code got=%0h want=0", cmd_code);
    end
`ifdef LCD_RX_STATS_EN
    total++;
    if ({frame_cnt, px_cnt, err_cnt} !== 44'd0) begin
      bad++;
      $display("[TB] FAIL reset_stats got=%0h want=0", {frame_cnt, px_cnt, err_cnt});
    end
`endif
    resetN = 1'b1;
    settle();
    total++;
    if (pq.size() != 0 || cmd_seen != 0) begin
      bad++;
      $display("[TB] FAIL reset_release_quiet got=%0d/%0d want=0/0", pq.size(), cmd_seen);
    end
  endtask

  task automatic test_window_fill();
    pix_t e;
    pq.delete();
    send_cmd(8'h2A);
    send_data(8'h00); send_data(8'h00); send_data(8'h00); send_data(8'h03);
    send_cmd(8'h2B);
    send_data(8'h00); send_data(8'h00); send_data(8'h00); send_data(8'h01);
    send_cmd(8'h2C);
    for (int i = 0; i < 8; i++) begin
      send_data(8'hF8);
      send_data(8'h00);
    end
    settle();
    total++;
    if (pq.size() != 8) begin
      bad++;
      $display("[TB] FAIL fill_count got=%0d want=8", pq.size());
    end
    for (int i = 0; i < 8 && i < pq.size(); i++) begin
      e = {10'(i % 4), 9'(i / 4), 12'hF00, (i == 0)};
      total++;
      if (pq[i] !== e) begin
        bad++;
        $display("[TB] FAIL fill_px%0d got=(%0d,%0d,%h,%b) want=(%0d,%0d,%h,%b)", i,
                 pq[i].x, pq[i].y, pq[i].rgb, pq[i].fs, e.x, e.y, e.rgb, e.fs);
      end
    end
    total++;
    if (cmd_seen != 3 || cmd_code !== 8'h2C) begin
      bad++;
      $display("[TB] FAIL fill_cmds got=%0d/%h want=3/2c", cmd_seen, cmd_code);
    end
  endtask

  task automatic test_wrap();
    pix_t e;
    pq.delete();
    send_data(8'hF8);
    send_data(8'h00);
    settle();
    e = {10'd0, 9'd0, 12'hF00, 1'b1};
    total++;
    if (pq.size() != 1 || pq[0] !== e) begin
      bad++;
      $display("[TB] FAIL wrap_px got=%0d entries first=%h want=1 entry %h", pq.size(),
               (pq.size() > 0) ? pq[0] : pix_t'(0), e);
    end
  endtask

  task automatic test_clamp();
    pix_t e0, e1;
    pq.delete();
    send_cmd(8'h2A);
    send_data(8'h02); send_data(8'h90); send_data(8'h00); send_data(8'h05);
    send_cmd(8'h2C);
    for (int i = 0; i < 2; i++) begin
      send_data(8'h07);
      send_data(8'hE0);
    end
    settle();
    e0 = {10'd639, 9'd0, 12'h0F0, 1'b1};
    e1 = {10'd639, 9'd1, 12'h0F0, 1'b0};
    total++;
    if (pq.size() != 2) begin
      bad++;
      $display("[TB] FAIL clamp_count got=%0d want=2", pq.size());
    end else begin
      total++;
      if (pq[0] !== e0) begin
        bad++;
        $display("[TB] FAIL clamp_px0 got=%h want=%h", pq[0], e0);
      end
      total++;
      if (pq[1] !== e1) begin
        bad++;
        $display("[TB] FAIL clamp_px1 got=%h want=%h", pq[1], e1);
      end
    end
  endtask

  task automatic test_abort();
    pq.delete();
    send_cmd(8'h2C);
    send_data(8'hF8);
    send_cmd(8'h2A);
    settle();
    total++;
    if (pq.size() != 0) begin
      bad++;
      $display("[TB] FAIL abort_no_pixel got=%0d want=0", pq.size());
    end
    total++;
    if (cmd_code !== 8'h2A || cmd_seen != 7) begin
      bad++;
      $display("[TB] FAIL abort_cmd got=%h/%0d want=2a/7", cmd_code, cmd_seen);
    end
`ifdef LCD_RX_STATS_EN
    total++;
    if (err_cnt !== 8'd1) begin
      bad++;
      $display("[TB] FAIL abort_err_cnt got=%0d want=1", err_cnt);
    end
`endif
  endtask

  task automatic test_soft_reset();
    pix_t e;
    pq.delete();
    send_cmd(8'h2C);
    send_data(8'hF8);
    @(posedge clk);
    #1;
    lcd_reset = 1'b0;
    repeat (3) @(posedge clk);
    send_data(8'h00);
    settle();
    #1;
    total++;
    if (pq.size() != 0 || pxl_rgb !== 12'h000 || pxl_x !== 10'd0) begin
      bad++;
      $display("[TB] FAIL softrst_quiet got=%0d/%h/%0d want=0/000/0", pq.size(), pxl_rgb, pxl_x);
    end
    total++;
    if (cmd_code !== 8'h2C) begin
      bad++;
      $display("[TB] FAIL softrst_cmd_kept got=%h want=2c", cmd_code);
    end
    lcd_reset = 1'b1;
    settle();
    send_cmd(8'h2C);
    for (int i = 0; i < 641; i++) begin
      send_data(8'hA5);
      send_data(8'h3C);
    end
    settle();
    total++;
    if (pq.size() != 641) begin
      bad++;
      $display("[TB] FAIL softrst_count got=%0d want=641", pq.size());
    end else begin
      e = {10'd0, 9'd0, 12'hAAE, 1'b1};
      total++;
      if (pq[0] !== e) begin
        bad++;
        $display("[TB] FAIL softrst_px0 got=%h want=%h", pq[0], e);
      end
      e = {10'd639, 9'd0, 12'hAAE, 1'b0};
      total++;
      if (pq[639] !== e) begin
        bad++;
        $display("[TB] FAIL softrst_px639 got=%h want=%h", pq[639], e);
      end
      e = {10'd0, 9'd1, 12'hAAE, 1'b0};
      total++;
      if (pq[640] !== e) begin
        bad++;
        $display("[TB] FAIL softrst_px640 got=%h want=%h", pq[640], e);
      end
    end
  endtask

  task automatic test_rd_and_latency();
    pix_t e;
    int lat;
    bit found;
    pq.delete();
    bus_write(1'b1, 8'hA5, 1'b0);
    send_data(8'hF8);
    @(posedge clk);
    #1;
    lcd_d_c = 1'b1;
    lcd_db  = 8'h00;
    lcd_rd  = 1'b1;
    lcd_wr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lcd_wr = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (pxl_valid) found = 1'b1;
    end
    total++;
    if (!found || lat != 3) begin
      bad++;
      $display("[TB] FAIL latency got=%0d found=%b want=3", lat, found);
    end
    settle();
    e = {10'd1, 9'd1, 12'hF00, 1'b0};
    total++;
    if (pq.size() != 1 || pq[0] !== e) begin
      bad++;
      $display("[TB] FAIL rd_ignored got=%0d entries first=%h want=1 entry %h", pq.size(),
               (pq.size() > 0) ? pq[0] : pix_t'(0), e);
    end
  endtask

  initial begin
    test_reset();
    test_window_fill();
    test_wrap();
    test_clamp();
    test_abort();
    test_soft_reset();
    test_rd_and_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
